// File: rtl/fp_addsub_mc.sv
// Multi-cycle IEEE-754 adder/subtractor, parametrised exponent/mantissa widths, round-to-nearest-even.
// Define FPADD_DENORM_EN for gradual underflow; otherwise subnormals are flushed to signed zero.
module fp_addsub_mc #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   sub,
  input  logic                   load,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             status,
  output logic [EXP_W+MAN_W:0]   sum
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_ONE = 1;
  localparam logic [EXP_W:0]   E_ONE   = 1;
  localparam logic [W-1:0]     QNAN    = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND} state_t;
  state_t state_q, state_d;

  logic [W-1:0]     a_q, b_q;
  logic             sa_q, sb_q, spec_q, flush_q;
  logic [W-1:0]     spec_sum_q;
  logic [2:0]       spec_status_q;
  logic [EXP_W-1:0] ea_q, eb_q, ex_q;
  logic [MAN_W:0]   ma_q, mb_q;
  logic             sx_q, eff_sub_q, zero_sign_q, zero_q;
  logic [SW-1:0]    gx_q, gy_q, n_q;
  logic [SW:0]      raw_q;
  logic [EXP_W:0]   e_q;

  // Unpack: field split, classification, special-case resolution
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic             a_inf, b_inf, a_nan, b_nan;
  logic [EXP_W-1:0] u_ea, u_eb;
  logic [MAN_W:0]   u_ma, u_mb;
  logic             u_spec, u_flush;
  logic [W-1:0]     u_spec_sum;
  logic [2:0]       u_spec_status;

  assign a_exp  = a_q[W-2:MAN_W];
  assign b_exp  = b_q[W-2:MAN_W];
  assign a_frac = a_q[MAN_W-1:0];
  assign b_frac = b_q[MAN_W-1:0];
  assign a_inf  = (a_exp == EXP_MAX) && (a_frac == '0);
  assign b_inf  = (b_exp == EXP_MAX) && (b_frac == '0);
  assign a_nan  = (a_exp == EXP_MAX) && (a_frac != '0);
  assign b_nan  = (b_exp == EXP_MAX) && (b_frac != '0);

  always_comb begin
    // Zeros and subnormals both sit at exponent 1 so alignment needs no special case.
    u_ea = (a_exp == '0) ? EXP_ONE : a_exp;
    u_eb = (b_exp == '0) ? EXP_ONE : b_exp;
`ifdef FPADD_DENORM_EN
    u_ma    = {a_exp != '0, a_frac};
    u_mb    = {b_exp != '0, b_frac};
    u_flush = 1'b0;
`else
    u_ma    = (a_exp != '0) ? {1'b1, a_frac} : '0;
    u_mb    = (b_exp != '0) ? {1'b1, b_frac} : '0;
    u_flush = ((a_exp == '0) && (a_frac != '0)) || ((b_exp == '0) && (b_frac != '0));
`endif
    u_spec        = 1'b0;
    u_spec_sum    = '0;
    u_spec_status = 3'b000;
    if (a_nan || b_nan || (a_inf && b_inf && (a_q[W-1] != b_q[W-1]))) begin
      u_spec        = 1'b1;
      u_spec_sum    = QNAN;
      u_spec_status = 3'b100;
    end else if (a_inf) begin
      u_spec        = 1'b1;
      u_spec_sum    = a_q;
      u_spec_status = 3'b010;
    end else if (b_inf) begin
      u_spec        = 1'b1;
      u_spec_sum    = b_q;
      u_spec_status = 3'b010;
    end
  end

  // Align: order by magnitude, shift the smaller significand right with sticky collection
  logic             swap;
  logic [EXP_W-1:0] al_ex, al_ey, al_d;
  logic [MAN_W:0]   al_mx, al_my;
  logic [SW-1:0]    al_full, al_gy;

  always_comb begin
    swap    = {eb_q, mb_q} > {ea_q, ma_q};
    al_ex   = swap ? eb_q : ea_q;
    al_ey   = swap ? ea_q : eb_q;
    al_mx   = swap ? mb_q : ma_q;
    al_my   = swap ? ma_q : mb_q;
    al_d    = al_ex - al_ey;
    al_full = {al_my, 3'b000};
    if (32'(al_d) >= 32'(SW - 1))
      al_gy = {{(SW-1){1'b0}}, |al_my};
    else
      al_gy = (al_full >> al_d) |
              {{(SW-1){1'b0}}, |(al_full & ~({SW{1'b1}} << al_d))};
  end

  // Normalise: carry shifts right one place, otherwise shift left by LZC clamped at exponent 1
  function automatic int lzc(input logic [SW-1:0] v);
    lzc = SW;
    for (int i = 0; i < SW; i++)
      if (v[i]) lzc = SW - 1 - i;
  endfunction

  logic [SW-1:0]  nm_n;
  logic [EXP_W:0] nm_e;
  int             nm_lim, nm_sh;

  always_comb begin
    nm_n   = '0;
    nm_e   = e_q;
    nm_lim = int'(e_q) - 1;
    nm_sh  = 0;
    if (raw_q[SW]) begin
      nm_n    = raw_q[SW:1];
      nm_n[0] = raw_q[1] | raw_q[0];
      nm_e    = e_q + E_ONE;
    end else begin
      nm_sh = (lzc(raw_q[SW-1:0]) < nm_lim) ? lzc(raw_q[SW-1:0]) : nm_lim;
      nm_n  = raw_q[SW-1:0] << nm_sh;
      nm_e  = e_q - nm_sh[EXP_W:0];
    end
  end

  // Round to nearest even and pack
  logic           rd_inc;
  logic [MAN_W+1:0] rd_rnd;
  logic [MAN_W:0] rd_mant;
  logic [EXP_W:0] rd_e;
  logic [W-1:0]   rd_sum;
  logic [2:0]     rd_status;

  always_comb begin
    rd_inc = n_q[2] & (n_q[1] | n_q[0] | n_q[3]);
    rd_rnd = {1'b0, n_q[SW-1:3]} + {{(MAN_W+1){1'b0}}, rd_inc};
    if (rd_rnd[MAN_W+1]) begin
      rd_mant = rd_rnd[MAN_W+1:1];
      rd_e    = e_q + E_ONE;
    end else begin
      rd_mant = rd_rnd[MAN_W:0];
      rd_e    = e_q;
    end
    rd_sum    = {sx_q, rd_e[EXP_W-1:0], rd_mant[MAN_W-1:0]};
    rd_status = {2'b00, flush_q};
    if (spec_q) begin
      rd_sum    = spec_sum_q;
      rd_status = spec_status_q;
    end else if (zero_q) begin
      rd_sum = {zero_sign_q, {(W-1){1'b0}}};
    end else if (rd_e >= {1'b0, EXP_MAX}) begin
      rd_sum    = {sx_q, EXP_MAX, {MAN_W{1'b0}}};
      rd_status = 3'b010;
    end else if (!rd_mant[MAN_W]) begin
      rd_status = 3'b001;
`ifdef FPADD_DENORM_EN
      rd_sum    = {sx_q, {EXP_W{1'b0}}, rd_mant[MAN_W-1:0]};
`else
      rd_sum    = {sx_q, {(W-1){1'b0}}};
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load) state_d = UNPACK;
      UNPACK:  state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign busy = (state_q != IDLE);

  // NOTE: datapath registers are reset too, so an aborted operation leaves no stale state behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;  b_q <= '0;  sa_q <= 1'b0;  sb_q <= 1'b0;
      ea_q <= '0; eb_q <= '0; ma_q <= '0;    mb_q <= '0;
      spec_q <= 1'b0; spec_sum_q <= '0; spec_status_q <= '0; flush_q <= 1'b0;
      ex_q <= '0; gx_q <= '0; gy_q <= '0; sx_q <= 1'b0;
      eff_sub_q <= 1'b0; zero_sign_q <= 1'b0; zero_q <= 1'b0;
      raw_q <= '0; e_q <= '0; n_q <= '0;
      sum <= '0; status <= 3'b000; done <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: if (load) begin
          a_q <= a;
          b_q <= {b[W-1] ^ sub, b[W-2:0]};
        end
        UNPACK: begin
          sa_q <= a_q[W-1];  sb_q <= b_q[W-1];
          ea_q <= u_ea;      eb_q <= u_eb;
          ma_q <= u_ma;      mb_q <= u_mb;
          spec_q <= u_spec;  spec_sum_q <= u_spec_sum;
          spec_status_q <= u_spec_status;
          flush_q <= u_flush;
        end
        ALIGN: begin
          ex_q        <= al_ex;
          gx_q        <= {al_mx, 3'b000};
          gy_q        <= al_gy;
          sx_q        <= swap ? sb_q : sa_q;
          eff_sub_q   <= sa_q ^ sb_q;
          zero_sign_q <= sa_q & sb_q;
        end
        ADD: begin
          raw_q <= eff_sub_q ? ({1'b0, gx_q} - {1'b0, gy_q}) : ({1'b0, gx_q} + {1'b0, gy_q});
          e_q   <= {1'b0, ex_q};
        end
        NORM: begin
          n_q    <= nm_n;
          e_q    <= nm_e;
          zero_q <= (raw_q == '0);
        end
        ROUND: begin
          sum    <= rd_sum;
          status <= rd_status;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
